// File: rtl/alu_result_buffer.sv
// Two-entry elastic buffer capturing ALU results (y, cout, zero, sel) with a
// valid/ready handshake and status counters. Optional macro: ALU_RES_ZCHECK_EN.
module alu_result_buffer #(
  parameter int unsigned N  = 32,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_y,
  input  logic          in_cout,
  input  logic          in_zero,
  input  logic [2:0]    in_sel,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_y,
  output logic          out_cout,
  output logic          out_zero,
  output logic [2:0]    out_sel,
  input  logic          stat_clr,
  output logic [CW-1:0] zero_cnt,
  output logic          carry_sticky
`ifdef ALU_RES_ZCHECK_EN
  ,
  output logic          zchk_err
`endif
);

  localparam int unsigned EW = N + 5;
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;
  localparam logic [CW-1:0] ZMAX = {CW{1'b1}};

  logic [1:0]    state, next_state;
  logic [EW-1:0] h_q, t_q, in_ent;
  logic          push_c, pop_c, load_h_c, load_t_c, shift_c, carry_set_c;

  assign in_ent = {in_sel, in_zero, in_cout, in_y};
  assign push_c = in_valid && in_ready;
  assign pop_c  = out_valid && out_ready;

  // Next-state and entry-load decode
  always_comb begin
    next_state = state;
    load_h_c   = 1'b0;
    load_t_c   = 1'b0;
    shift_c    = 1'b0;
    case (state)
      EMPTY: begin
        if (push_c) begin
          next_state = ONE;
          load_h_c   = 1'b1;
        end
      end
      ONE: begin
        if (push_c && !pop_c) begin
          next_state = FULL;
          load_t_c   = 1'b1;
        end else if (!push_c && pop_c) begin
          next_state = EMPTY;
        end else if (push_c && pop_c) begin
          load_h_c   = 1'b1;
        end
      end
      FULL: begin
        if (pop_c) begin
          next_state = ONE;
          shift_c    = 1'b1;
        end
      end
      default: next_state = EMPTY;
    endcase
  end

  // Handshake flags are registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= next_state;
      in_ready  <= (next_state != FULL);
      out_valid <= (next_state != EMPTY);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= '0;
      t_q <= '0;
    end else begin
      if (load_h_c)     h_q <= in_ent;
      else if (shift_c) h_q <= t_q;
      if (load_t_c)     t_q <= in_ent;
    end
  end

  assign {out_sel, out_zero, out_cout, out_y} = h_q;

  // Carry/borrow only matters for the add/sub select codes
  assign carry_set_c = push_c && in_cout && ((in_sel == 3'b010) || (in_sel == 3'b011));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_cnt     <= '0;
      carry_sticky <= 1'b0;
    end else if (stat_clr) begin
      zero_cnt     <= '0;
      carry_sticky <= 1'b0;
    end else begin
      if (push_c && in_zero && (zero_cnt != ZMAX)) zero_cnt <= zero_cnt + CW'(1);
      if (carry_set_c) carry_sticky <= 1'b1;
    end
  end

`ifdef ALU_RES_ZCHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        zchk_err <= 1'b0;
    else if (stat_clr) zchk_err <= 1'b0;
    else if (push_c && ((in_y == '0) != in_zero)) zchk_err <= 1'b1;
  end
`endif

endmodule
